// File: rtl/wash_billing_meter_pkg.sv
// Package billing_pkg: shared types and helpers for the wash billing meter.
//   state_t   : meter FSM states
//   SEG_*     : active-low 7-segment codes, bit order {dp,g,f,e,d,c,b,a}
//   DIG_DASH  : non-BCD digit code the display path uses to request a dash
//   seg_code  : digit code -> segment pattern
//   bin2bcd   : 32-bit binary -> 10-digit packed BCD (double-dabble)
package billing_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXHAUST} state_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [3:0] DIG_DASH  = 4'hA;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:     s = SEG_0;
      4'd1:     s = SEG_1;
      4'd2:     s = SEG_2;
      4'd3:     s = SEG_3;
      4'd4:     s = SEG_4;
      4'd5:     s = SEG_5;
      4'd6:     s = SEG_6;
      4'd7:     s = SEG_7;
      4'd8:     s = SEG_8;
      4'd9:     s = SEG_9;
      DIG_DASH: s = SEG_DASH;
      default:  s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Shift-and-add-3: any BCD nibble >= 5 gets +3 before each left shift.
  function automatic logic [39:0] bin2bcd(input logic [31:0] bin);
    logic [39:0] bcd;
    bcd = '0;
    for (int i = 31; i >= 0; i--) begin
      for (int d = 0; d < 10; d++)
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      bcd = {bcd[38:0], bin[i]};
    end
    return bcd;
  endfunction

endpackage

// File: rtl/wash_billing_meter_if.sv
// Panel/meter signal bundle.
//   master : panel side  - drives on/start/bal, observes meter outputs
//   slave  : meter side  - drives remain/charge/done/seg/ena/st_light
interface wash_billing_meter_if #(
  parameter int BAL_W  = 12,
  parameter int DIGITS = 4
);
  logic              on;
  logic              start;
  logic [BAL_W-1:0]  bal;
  logic [BAL_W-1:0]  remain;
  logic [BAL_W-1:0]  charge;
  logic              done;
  logic [7:0]        seg;
  logic [DIGITS-1:0] ena;
  logic [7:0]        st_light;

  modport master (output on, start, bal,
                  input  remain, charge, done, seg, ena, st_light);
  modport slave  (input  on, start, bal,
                  output remain, charge, done, seg, ena, st_light);
endinterface

// File: rtl/wash_billing_meter_seg_scan.sv
// seg_scan_n: multiplexed 7-segment scanner.
//   clk, rst  : clock, async active-low reset
//   digit_i   : per-digit code (0-9, DIG_DASH, anything else blank)
//   blank_i   : per-digit blank mask (leading-zero suppression)
//   off_i     : blank the whole display (all enables high)
//   seg_o     : active-low segments {dp,g..a}, registered
//   ena_o     : active-low digit enables, registered
// Digit 0 is shown first; the selector advances every SCAN_DIV cycles.
module seg_scan_n
  import billing_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIGITS-1:0][3:0] digit_i,
  input  logic [DIGITS-1:0]      blank_i,
  input  logic                   off_i,
  output logic [7:0]             seg_o,
  output logic [DIGITS-1:0]      ena_o
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DIGITS);

  logic [CW-1:0]     scan_q, scan_d;
  logic [DW-1:0]     sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] ena_q, ena_d;

  always_comb begin
    scan_d = scan_q + 1'b1;
    sel_d  = sel_q;
    if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      sel_d  = (sel_q == DW'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
    end
    seg_d = blank_i[sel_q] ? SEG_BLANK : seg_code(digit_i[sel_q]);
    ena_d = '1;
    if (!off_i) ena_d[sel_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q <= '0;
      sel_q  <= '0;
      seg_q  <= SEG_BLANK;
      ena_q  <= '1;
    end else begin
      scan_q <= scan_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
      ena_q  <= ena_d;
    end
  end

  assign seg_o = seg_q;
  assign ena_o = ena_q;
endmodule

// File: rtl/wash_billing_meter.sv
// wash_billing_meter: pay-per-time meter for the washer controller.
// Latches a prepaid balance on start and charges one unit every
// CHARGE_SECS ticks of RUN time; pauses while on is low.
//   clk, rst : clock, async active-low reset
//   bus      : wash_billing_meter_if.slave (on/start/bal in;
//              remain/charge/done/seg/ena/st_light out)
// Optional feature macro: BILL_LOWBAL_WARN_EN (low-balance warning on
// st_light[5] plus display blinking on alternate ticks).
module wash_billing_meter
  import billing_pkg::*;
#(
  parameter int TICK_DIV    = 100_000_000,
  parameter int CHARGE_SECS = 10,
  parameter int DIGITS      = 4,
  parameter int BAL_W       = 12,
  parameter int SCAN_DIV    = 100_000,
  parameter int LOW_THRESH  = 5
) (
  input logic                clk,
  input logic                rst,
  wash_billing_meter_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (CHARGE_SECS > 1) ? $clog2(CHARGE_SECS) : 1;
`ifdef BILL_LOWBAL_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [SW-1:0]    sec_q, sec_d;
  logic [BAL_W-1:0] remain_q, remain_d;
  logic [BAL_W-1:0] charge_q, charge_d;
  logic             err_q, err_d;
  logic             tgl_q, tgl_d;
  logic             done_q, done_d;
  logic [7:0]       st_q, st_d;
  logic             warn_d;

  // Next-state. Counting is keyed off the registered RUN state, so a tick
  // or charge landing in the same cycle as a stop or an on fall is still
  // applied before the state changes.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    sec_d    = sec_q;
    remain_d = remain_q;
    charge_d = charge_q;
    err_d    = err_q;
    tgl_d    = tgl_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ($signed(bus.bal) > $signed(BAL_W'(0))) begin
            remain_d = bus.bal;
            charge_d = '0;
            tick_d   = '0;
            sec_d    = '0;
            err_d    = 1'b0;
            tgl_d    = 1'b0;
            state_d  = bus.on ? RUN : PAUSE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (tick_q == TW'(TICK_DIV - 1)) begin
          tick_d = '0;
          tgl_d  = ~tgl_q;
          if (sec_q == SW'(CHARGE_SECS - 1)) begin
            sec_d = '0;
            if (remain_q != '0) begin
              remain_d = remain_q - 1'b1;
              charge_d = charge_q + 1'b1;
            end
          end else begin
            sec_d = sec_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
        if (bus.start)            state_d = IDLE;
        else if (remain_d == '0)  state_d = EXHAUST;
        else if (!bus.on)         state_d = PAUSE;
      end
      PAUSE: begin
        if (bus.start)   state_d = IDLE;
        else if (bus.on) state_d = RUN;
      end
      EXHAUST: begin
        if (bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == EXHAUST);
    warn_d = WARN_EN && (state_d == RUN || state_d == PAUSE) &&
             (remain_d <= BAL_W'(LOW_THRESH));
    st_d   = {err_d, 1'b0, warn_d, tgl_d,
              state_d == EXHAUST, state_d == PAUSE,
              state_d == RUN, state_d == IDLE};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      sec_q    <= '0;
      remain_q <= '0;
      charge_q <= '0;
      err_q    <= 1'b0;
      tgl_q    <= 1'b0;
      done_q   <= 1'b0;
      st_q     <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      sec_q    <= sec_d;
      remain_q <= remain_d;
      charge_q <= charge_d;
      err_q    <= err_d;
      tgl_q    <= tgl_d;
      done_q   <= done_d;
      st_q     <= st_d;
    end
  end

  // Display value -> digit codes. Digits past DIGITS being non-zero means
  // the value does not fit, so every position shows a dash instead.
  logic [BAL_W-1:0]      disp_val;
  logic [39:0]           bcd;
  logic                  ovf, lead;
  logic [DIGITS-1:0][3:0] dig;
  logic [DIGITS-1:0]     blank;
  logic                  blank_all;

  always_comb begin
    disp_val = (state_q == IDLE) ? charge_q : remain_q;
    bcd      = bin2bcd(32'(disp_val));
    ovf      = 1'b0;
    lead     = 1'b1;
    dig      = '0;
    blank    = '0;
    for (int d = DIGITS; d < 10; d++)
      if (bcd[d*4 +: 4] != 4'd0) ovf = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dig[d] = ovf ? DIG_DASH : bcd[d*4 +: 4];
      if (d != 0 && lead && !ovf && bcd[d*4 +: 4] == 4'd0) blank[d] = 1'b1;
      else lead = 1'b0;
    end
  end

  // Warning blink: display off during the tick periods where the tick
  // toggle bit is high.
  assign blank_all = WARN_EN && st_q[5] && tgl_q;

  seg_scan_n #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .digit_i (dig),
    .blank_i (blank),
    .off_i   (blank_all),
    .seg_o   (bus.seg),
    .ena_o   (bus.ena)
  );

  assign bus.remain   = remain_q;
  assign bus.charge   = charge_q;
  assign bus.done     = done_q;
  assign bus.st_light = st_q;
endmodule
